iot_mux: RTL and testbench
==========================

# iot_mux

Parametrised IOT multiplexer between the PDP-8/E CPU and N peripheral channels. It is the only path by which device data and skip conditions reach the CPU. It decodes IOT device codes against a per-channel table and routes read data and skip. It also issues a registered one-cycle IOT select strobe to the addressed device, latches and prioritises device interrupt requests at instruction boundaries, and maintains the front-panel bus display.

## Interface
- NCHAN, 4: number of device channels (1..16)
- DEV_CODES, 0: NCHAN×6-bit packed device codes; channel i is bits [6i+5:6i]
- RD_MASK, 0: NCHAN×8-bit packed mask; bit f set means IOT function f of channel i reads the channel's data onto in_bus
- SK_MASK, 0: NCHAN×8-bit packed mask; bit f set means function f of channel i returns that channel's skip
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- state  in  5  CPU major state code (F2/F3 from the shared parameters)
- instruction  in  [0:11]  current instruction
- ac  in  [0:11]  accumulator
- dev_bus  in  NCHAN×12  packed device read data; channel i is bits [12i+11:12i]
- dev_skip  in  NCHAN  per-channel skip condition
- dev_irq  in  NCHAN  per-channel interrupt request (level)
- EAE_skip  in  1  EAE skip condition
- skip  out  1  combinational skip to the CPU
- in_bus  out  [0:11]  combinational read data to the CPU
- dev_sel  out  NCHAN  registered one-hot IOT strobe
- irq  out  1  registered OR of the latched requests
- irq_chan  out  4  index of the highest-priority latched request
- bus_display  out  [0:11]  front-panel bus value

## Operation
- An IOT is recognised when instruction[0:2]==3'o6. Device code = instruction[3:8]; function f = instruction[9:11].
- Match vector: m[i] = IOT && DEV_CODES[i]==device code. The lowest index wins when several channels match, which is a configuration error.
- in_bus = dev_bus of the winning channel if RD_MASK[i][f] is set, else 12'o0000.
- skip, in this order:
  - EAE pattern 12'b1111???????1 gives EAE_skip.
  - Otherwise the winning channel with SK_MASK[i][f] set gives dev_skip[i].
  - Otherwise 0.
- At state==F2:
  - lac <= ac.
  - lin_bus <= in_bus.
  - sel_q <= one-hot of the winning channel (zero if none).
- At state==F3:
  - dev_sel <= sel_q for exactly one cycle; dev_sel is 0 in every other cycle.
  - bus_display <= lin_bus if the winner's RD_MASK bit for f is set.
  - Else bus_display <= lac if a channel matched.
  - Else bus_display holds.
- Interrupts:
  - irq_lat <= dev_irq only in F3 cycles; it holds otherwise.
  - irq = |irq_lat.
  - irq_chan = lowest set index of irq_lat, 0 when none.
- Reset clears lac, lin_bus, sel_q, dev_sel, irq_lat and bus_display. Consequently irq=0 and irq_chan=0.

## Timing
- skip and in_bus have zero latency; they are valid in the same cycle the instruction is stable.
- dev_sel is high in the cycle after the F3 cycle, for one cycle.
- bus_display, irq and irq_chan update at the F3 clock edge.
- A device raising dev_irq between F3 cycles is not seen until the next F3.
- A reset asserted in the F2 or F3 cycle suppresses that instruction's dev_sel pulse. Reset has priority over all loads.
- If an F3 cycle occurs without a preceding F2, the stale sel_q and lin_bus are used. This is permitted, because the CPU always passes through F2.

## Configuration
- IOT_MUX_DIAG_EN defined:
  - An 8-bit saturating counter unclaimed_cnt increments at each F3 in which an IOT matched no channel.
  - unclaimed_ir latches that instruction.
  - Both are output ports and reset to 0.
  - The counter sticks at 8'hFF.
- IOT_MUX_DIAG_EN undefined: these ports and registers do not exist.

## Structure
- The shared package holds:
  - the major-state constants (F2, F3);
  - the IOT field positions (opcode 0:2, device 3:8, function 9:11);
  - the EAE skip pattern.
- Sub-module iot_prio_enc(NCHAN) is a lowest-index-first priority encoder, instantiated twice:
  - on the match vector, to produce the winner and its one-hot;
  - on irq_lat, to produce irq_chan.

## Test plan
- NCHAN=4, DEV_CODES={03,04,21,74}, RD_MASK[1]=8'h40. Instruction 6046 with dev_bus[1]=0o1234:
  - in_bus=0o1234 in the same cycle;
  - dev_sel=4'b0010 for one cycle after F3;
  - bus_display=0o1234.
- SK_MASK[0]=8'h02, instruction 6031, dev_skip[0]=1 → skip=1. With dev_skip[0]=0 → skip=0. Instruction 6041 with dev_skip[1]=1 and SK_MASK[1][1]=0 → skip=0.
- Instruction 7441 (EAE pattern), EAE_skip=1 → skip=1 and in_bus=0. Instruction 6033 with ac=0o5555 and no RD bit → bus_display=0o5555.
- dev_irq=4'b1100 raised mid-instruction → irq stays 0 until the F3 edge, then irq=1 and irq_chan=2. Clearing dev_irq[2] → irq_chan=3 after the next F3.
- Reset asserted during the F3 cycle of 6046 → no dev_sel pulse, and bus_display=0, irq=0, irq_chan=0.
- With IOT_MUX_DIAG_EN: 300 unclaimed IOTs (6551) → unclaimed_cnt=255 and unclaimed_ir=6551.

Source files
------------

// File: rtl/iot_mux_pkg.sv
// Shared definitions for the IOT multiplexer: CPU major-state codes,
// instruction field positions and the EAE skip pattern.
package iot_mux_pkg;

    typedef logic [0:11] word_t;

    // CPU major-state codes seen on the state input
    localparam logic [4:0] ST_F2 = 5'd2;
    localparam logic [4:0] ST_F3 = 5'd3;

    // Instruction field positions (bit 0 is the MSB)
    localparam int IR_OP_MSB  = 0;
    localparam int IR_OP_LSB  = 2;
    localparam int IR_DEV_MSB = 3;
    localparam int IR_DEV_LSB = 8;
    localparam int IR_FN_MSB  = 9;
    localparam int IR_FN_LSB  = 11;

    localparam logic [2:0] OP_IOT = 3'o6;

    // EAE skip pattern 1111_xxxx_xxx1
    localparam word_t EAE_SKIP_MASK = 12'o7401;
    localparam word_t EAE_SKIP_VAL  = 12'o7401;

    function automatic logic is_eae_skip(input word_t ir);
        return (ir & EAE_SKIP_MASK) == EAE_SKIP_VAL;
    endfunction

endpackage

// File: rtl/iot_prio_enc.sv
// Lowest-index-first priority encoder: index, one-hot and valid of the
// lowest set request bit. Index is 0 and one-hot is 0 when nothing is set.
module iot_prio_enc
    import iot_mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic         o_valid,
    output logic [3:0]   o_idx,
    output logic [N-1:0] o_onehot
);

    // Scan from the top down so the lowest set index is the last to win
    always_comb begin
        o_idx    = '0;
        o_onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx       = 4'(i);
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
            end
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/iot_mux.sv
// IOT multiplexer between the PDP-8/E CPU and NCHAN device channels.
// Decodes IOT device codes, routes read data and skip, issues the
// one-cycle device select strobe, latches interrupts at F3 and drives the
// front-panel bus display.
// Optional build macro IOT_MUX_DIAG_EN adds an unclaimed-IOT counter and
// the last unclaimed instruction as extra outputs.
module iot_mux
    import iot_mux_pkg::*;
#(
    parameter int                  NCHAN     = 4,
    parameter logic [NCHAN*6-1:0]  DEV_CODES = '0,
    parameter logic [NCHAN*8-1:0]  RD_MASK   = '0,
    parameter logic [NCHAN*8-1:0]  SK_MASK   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [4:0]            i_state,
    input  logic [0:11]           i_instruction,
    input  logic [0:11]           i_ac,
    input  logic [NCHAN*12-1:0]   i_dev_bus,
    input  logic [NCHAN-1:0]      i_dev_skip,
    input  logic [NCHAN-1:0]      i_dev_irq,
    input  logic                  i_EAE_skip,
    output logic                  o_skip,
    output logic [0:11]           o_in_bus,
    output logic [NCHAN-1:0]      o_dev_sel,
    output logic                  o_irq,
    output logic [3:0]            o_irq_chan,
    output logic [0:11]           o_bus_display
`ifdef IOT_MUX_DIAG_EN
    ,
    output logic [7:0]            o_unclaimed_cnt,
    output logic [0:11]           o_unclaimed_ir
`endif
);

    logic             w_iot;
    logic [5:0]       w_dev;
    logic [2:0]       w_fn;
    logic [NCHAN-1:0] w_match;
    logic [NCHAN-1:0] w_rd_hit;
    logic [NCHAN-1:0] w_sk_hit;
    logic [NCHAN-1:0] w_win_oh;
    logic [3:0]       w_win_idx;
    logic             w_match_any;
    logic             w_rd_en;
    logic             w_dev_skip;
    logic             w_irq_any;

    logic [0:11]      r_lac;
    logic [0:11]      r_lin_bus;
    logic [NCHAN-1:0] r_sel_q;
    logic [NCHAN-1:0] r_dev_sel;
    logic [NCHAN-1:0] r_irq_lat;
    logic [0:11]      r_bus_display;

    assign w_iot = (i_instruction[IR_OP_MSB:IR_OP_LSB] == OP_IOT);
    assign w_dev = i_instruction[IR_DEV_MSB:IR_DEV_LSB];
    assign w_fn  = i_instruction[IR_FN_MSB:IR_FN_LSB];

    // Per-channel device-code match and the read/skip mask bits for this function
    always_comb begin
        w_match  = '0;
        w_rd_hit = '0;
        w_sk_hit = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_match[i]  = w_iot && (DEV_CODES[6*i +: 6] == w_dev);
            w_rd_hit[i] = RD_MASK[8*i + int'(w_fn)];
            w_sk_hit[i] = SK_MASK[8*i + int'(w_fn)];
        end
    end

    iot_prio_enc #(.N(NCHAN)) u_match_enc (
        .i_req    (w_match),
        .o_valid  (w_match_any),
        .o_idx    (w_win_idx),
        .o_onehot (w_win_oh)
    );

    assign w_rd_en    = |(w_win_oh & w_rd_hit);
    assign w_dev_skip = |(w_win_oh & w_sk_hit & i_dev_skip);

    // Zero-latency read data and skip; EAE pattern outranks any device
    always_comb begin
        o_in_bus = '0;
        if (w_rd_en) begin
            o_in_bus = i_dev_bus[int'(w_win_idx)*12 +: 12];
        end
        o_skip = is_eae_skip(i_instruction) ? i_EAE_skip : w_dev_skip;
    end

    // F2 captures, F3 strobe/display/interrupt latch; reset wins over all loads
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lac         <= '0;
            r_lin_bus     <= '0;
            r_sel_q       <= '0;
            r_dev_sel     <= '0;
            r_irq_lat     <= '0;
            r_bus_display <= '0;
        end else begin
            r_dev_sel <= '0;
            if (i_state == ST_F2) begin
                r_lac     <= i_ac;
                r_lin_bus <= o_in_bus;
                r_sel_q   <= w_win_oh;
            end
            if (i_state == ST_F3) begin
                r_dev_sel <= r_sel_q;
                r_irq_lat <= i_dev_irq;
                if (w_rd_en) begin
                    r_bus_display <= r_lin_bus;
                end else if (w_match_any) begin
                    r_bus_display <= r_lac;
                end
            end
        end
    end

    iot_prio_enc #(.N(NCHAN)) u_irq_enc (
        .i_req    (r_irq_lat),
        .o_valid  (w_irq_any),
        .o_idx    (o_irq_chan),
        .o_onehot ()
    );

    assign o_irq         = w_irq_any;
    assign o_dev_sel     = r_dev_sel;
    assign o_bus_display = r_bus_display;

`ifdef IOT_MUX_DIAG_EN
    logic [7:0]  r_unclaimed_cnt;
    logic [0:11] r_unclaimed_ir;

    // Count F3 cycles of IOTs nobody claimed, saturating at 8'hFF
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_unclaimed_cnt <= '0;
            r_unclaimed_ir  <= '0;
        end else if ((i_state == ST_F3) && w_iot && !w_match_any) begin
            r_unclaimed_ir <= i_instruction;
            if (r_unclaimed_cnt != 8'hFF) begin
                r_unclaimed_cnt <= r_unclaimed_cnt + 8'd1;
            end
        end
    end

    assign o_unclaimed_cnt = r_unclaimed_cnt;
    assign o_unclaimed_ir  = r_unclaimed_ir;
`else
    // Diagnostic counter not built
`endif

endmodule

// File: tb/tb_iot_mux.sv
// Self-checking bench for iot_mux (NCHAN=4).
module tb_iot_mux;
    import iot_mux_pkg::*;

    localparam int          NCH   = 4;
    localparam logic [23:0] P_DEV = {6'o74, 6'o21, 6'o04, 6'o03};
    localparam logic [31:0] P_RD  = {8'h00, 8'h10, 8'h40, 8'h00};
    localparam logic [31:0] P_SK  = {8'h80, 8'h00, 8'h00, 8'h02};
    localparam logic [4:0]  ST_IDLE = 5'd0;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    st;
    logic [11:0]   ir;
    logic [11:0]   ac;
    logic [47:0]   d_bus;
    logic [3:0]    d_skip;
    logic [3:0]    d_irq;
    logic          eae;
    logic          skip;
    logic [11:0]   in_bus;
    logic [3:0]    dsel;
    logic          irq;
    logic [3:0]    irq_chan;
    logic [11:0]   disp;
`ifdef IOT_MUX_DIAG_EN
    logic [7:0]    ucnt;
    logic [11:0]   uir;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] m_disp;

    typedef struct {
        logic [3:0]  sel;
        logic [11:0] disp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        string       nm;
        logic [11:0] ir;
        logic [47:0] bus;
        logic [3:0]  dskip;
        logic        eae;
        logic        exp_skip;
        logic [11:0] exp_bus;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    iot_mux #(
        .NCHAN     (NCH),
        .DEV_CODES (P_DEV),
        .RD_MASK   (P_RD),
        .SK_MASK   (P_SK)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_state       (st),
        .i_instruction (ir),
        .i_ac          (ac),
        .i_dev_bus     (d_bus),
        .i_dev_skip    (d_skip),
        .i_dev_irq     (d_irq),
        .i_EAE_skip    (eae),
        .o_skip        (skip),
        .o_in_bus      (in_bus),
        .o_dev_sel     (dsel),
        .o_irq         (irq),
        .o_irq_chan    (irq_chan),
        .o_bus_display (disp)
`ifdef IOT_MUX_DIAG_EN
        ,
        .o_unclaimed_cnt (ucnt),
        .o_unclaimed_ir  (uir)
`endif
    );

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o want %0o", nm, act, exp);
        end
    endtask

    // Reference decode: channel number, or -1 when the IOT is unclaimed
    function automatic int mdl_chan(input logic [11:0] w);
        if (w[11:9] != 3'o6) return -1;
        case (w[8:3])
            6'o03:   return 0;
            6'o04:   return 1;
            6'o21:   return 2;
            6'o74:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit mdl_rd(input int ch, input logic [2:0] f);
        return (ch == 1 && f == 3'd6) || (ch == 2 && f == 3'd4);
    endfunction

    // One IOT through F2 and F3; optional reset during F3
    task automatic run_instr(input logic [11:0] w, input logic [11:0] a, input bit rst_f3);
        sb_t e;
        int  ch;
        @(negedge clk);
        st = ST_F2; ir = w; ac = a;
        ch = mdl_chan(w);
        e.sel = (ch >= 0 && !rst_f3) ? 4'(1 << ch) : 4'd0;
        if (rst_f3)                    m_disp = 12'o0;
        else if (ch >= 0 && mdl_rd(ch, w[2:0])) m_disp = d_bus[12*ch +: 12];
        else if (ch >= 0)              m_disp = a;
        e.disp = m_disp;
        sbq.push_back(e);
        @(negedge clk);
        chk("dev_sel_in_f3", dsel, 4'd0);
        st = ST_F3; rst = rst_f3;
        @(negedge clk);
        st = ST_IDLE; rst = 1'b0;
        e = sbq.pop_front();
        chk("dev_sel_pulse", dsel, e.sel);
        chk("bus_display", disp, e.disp);
        @(negedge clk);
        chk("dev_sel_clear", dsel, 4'd0);
    endtask

    initial begin
        rst = 1'b1; st = ST_IDLE; ir = 12'o0; ac = 12'o0;
        d_bus = '0; d_skip = '0; d_irq = '0; eae = 1'b0;
        m_disp = 12'o0;
        repeat (3) @(negedge clk);
        chk("rst_dev_sel", dsel, 4'd0);
        chk("rst_disp", disp, 12'o0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_irq_chan", irq_chan, 4'd0);
`ifdef IOT_MUX_DIAG_EN
        chk("rst_ucnt", ucnt, 8'd0);
`endif
        rst = 1'b0;

        // Combinational decode table (bus: ch3 7777, ch2 4321, ch1 1234, ch0 0707)
        tv.push_back('{"rd_ch1",       12'o6046, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b0000, 1'b0, 1'b0, 12'o1234});
        tv.push_back('{"rd_ch2",       12'o6214, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b0000, 1'b0, 1'b0, 12'o4321});
        tv.push_back('{"rd_nomask",    12'o6045, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b0000, 1'b0, 1'b0, 12'o0000});
        tv.push_back('{"sk_ch0_hi",    12'o6031, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b0001, 1'b0, 1'b1, 12'o0000});
        tv.push_back('{"sk_ch0_lo",    12'o6031, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b0000, 1'b0, 1'b0, 12'o0000});
        tv.push_back('{"sk_ch1_nomsk", 12'o6041, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b0010, 1'b0, 1'b0, 12'o0000});
        tv.push_back('{"sk_ch3",       12'o6747, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b1000, 1'b0, 1'b1, 12'o0000});
        tv.push_back('{"eae_hi",       12'o7441, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b1111, 1'b1, 1'b1, 12'o0000});
        tv.push_back('{"eae_lo",       12'o7441, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b1111, 1'b0, 1'b0, 12'o0000});
        tv.push_back('{"eae_nopat",    12'o7440, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b1111, 1'b1, 1'b0, 12'o0000});
        tv.push_back('{"unclaimed",    12'o6551, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b1111, 1'b1, 1'b0, 12'o0000});
        tv.push_back('{"not_iot",      12'o5046, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b1111, 1'b0, 1'b0, 12'o0000});
        tv.push_back('{"iot_no_eae",   12'o6031, {12'o7777,12'o4321,12'o1234,12'o0707}, 4'b0000, 1'b1, 1'b0, 12'o0000});
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            ir = tv[i].ir; d_bus = tv[i].bus; d_skip = tv[i].dskip; eae = tv[i].eae;
            #2;
            chk({tv[i].nm, "_skip"}, skip, tv[i].exp_skip);
            chk({tv[i].nm, "_in_bus"}, in_bus, tv[i].exp_bus);
        end
        d_skip = '0; eae = 1'b0;

        // Multi-cycle transactions through the scoreboard
        d_bus = {12'o7777, 12'o4321, 12'o1234, 12'o0707};
        run_instr(12'o6046, 12'o0011, 1'b0);
        run_instr(12'o6033, 12'o5555, 1'b0);
        run_instr(12'o6551, 12'o2222, 1'b0);
        run_instr(12'o6214, 12'o0000, 1'b0);
        run_instr(12'o6747, 12'o3030, 1'b0);

        // Interrupts are sampled only on F3
        @(negedge clk);
        d_irq = 4'b1100;
        @(negedge clk);
        chk("irq_before_f2", irq, 1'b0);
        st = ST_F2; ir = 12'o6033; ac = 12'o0101;
        @(negedge clk);
        chk("irq_after_f2", irq, 1'b0);
        st = ST_F3;
        @(negedge clk);
        st = ST_IDLE;
        m_disp = 12'o0101;
        chk("irq_after_f3", irq, 1'b1);
        chk("irq_chan_2", irq_chan, 4'd2);
        chk("irq_disp", disp, m_disp);
        d_irq = 4'b1000;
        @(negedge clk);
        chk("irq_chan_hold", irq_chan, 4'd2);
        run_instr(12'o6031, 12'o0202, 1'b0);
        chk("irq_chan_3", irq_chan, 4'd3);
        chk("irq_still", irq, 1'b1);

        // Reset in the F3 cycle suppresses the strobe and clears state
        run_instr(12'o6046, 12'o0303, 1'b1);
        chk("rstf3_irq", irq, 1'b0);
        chk("rstf3_irq_chan", irq_chan, 4'd0);
        d_irq = 4'b0000;
        run_instr(12'o6033, 12'o0404, 1'b0);
        chk("irq_cleared", irq, 1'b0);

`ifdef IOT_MUX_DIAG_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_disp = 12'o0;
        chk("diag_rst_cnt", ucnt, 8'd0);
        chk("diag_rst_ir", uir, 12'o0);
        for (int k = 0; k < 300; k++) run_instr(12'o6551, 12'o0000, 1'b0);
        chk("diag_cnt_sat", ucnt, 8'hFF);
        chk("diag_ir", uir, 12'o6551);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
